// File: rtl/selector_posicion_param.sv
// Edit-cursor generator for the RTC setup path: moves the field address left/right inside the
// range of the active edit mode (crono/hora/fecha), with push-button auto-repeat.
module selector_posicion_param #(
  parameter int ADDR_W      = 8,
  parameter int CRONO_FIRST = 1,
  parameter int CRONO_LAST  = 4,
  parameter int HORA_FIRST  = 5,
  parameter int HORA_LAST   = 7,
  parameter int FECHA_FIRST = 8,
  parameter int FECHA_LAST  = 10,
  parameter int WRAP        = 1,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_PER  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] dir_in,
  input  logic [1:0]        push,
  input  logic              camb_crono,
  input  logic              camb_hora,
  input  logic              camb_fecha,
  output logic [ADDR_W-1:0] dir_out,
  output logic              dir_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_STEP,
    S_CLAMP,
    S_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    M_NONE,
    M_CRONO,
    M_HORA,
    M_FECHA
  } mode_t;

  localparam logic [1:0] PUSH_DEC = 2'b01;
  localparam logic [1:0] PUSH_INC = 2'b10;

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state, state_nxt;
  mode_t               mode, mode_q;
  logic [ADDR_W-1:0]   cursor, cursor_nxt;
  logic [ADDR_W-1:0]   lo, hi;
  logic [1:0]          push_q;
  logic                enable_q;
  logic [CNT_W-1:0]    hold_cnt, hold_cnt_nxt;
  logic                repeating, repeating_nxt;
  logic                wrap_en;
  logic                press, held, tick;

  function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] lo_b,
                                    input logic [ADDR_W-1:0] hi_b);
    return (a >= lo_b) && (a <= hi_b);
  endfunction

  always_comb begin
    if (camb_crono)      mode = M_CRONO;
    else if (camb_hora)  mode = M_HORA;
    else if (camb_fecha) mode = M_FECHA;
    else                 mode = M_NONE;
  end

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    lo = '0;
    hi = '1;
    unique case (mode)
      M_CRONO: begin lo = ADDR_W'(CRONO_FIRST); hi = ADDR_W'(CRONO_LAST); end
      M_HORA:  begin lo = ADDR_W'(HORA_FIRST);  hi = ADDR_W'(HORA_LAST);  end
      M_FECHA: begin lo = ADDR_W'(FECHA_FIRST); hi = ADDR_W'(FECHA_LAST); end
      default: ;
    endcase
  end

  // With no mode the range is the full address space, where stepping is plain modular arithmetic.
  assign wrap_en = (WRAP != 0) || (mode == M_NONE);

  assign press = ((push == PUSH_DEC) || (push == PUSH_INC)) && (push_q == 2'b00);
  assign held  = (push == push_q) && ((push == PUSH_DEC) || (push == PUSH_INC));
  assign tick  = held && (repeating ? (hold_cnt == CNT_W'(REPEAT_PER))
                                    : (hold_cnt == CNT_W'(REPEAT_DLY)));

  // After a tick the counter restarts at 1 so the next tick lands exactly REPEAT_PER cycles later.
  always_comb begin
    hold_cnt_nxt  = '0;
    repeating_nxt = 1'b0;
    if (held) begin
      if (tick) begin
        hold_cnt_nxt  = CNT_W'(1);
        repeating_nxt = 1'b1;
      end else begin
        hold_cnt_nxt  = hold_cnt + CNT_W'(1);
        repeating_nxt = repeating;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cursor_nxt = cursor;
    if ((state != S_IDLE) && !enable) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (enable && !enable_q) state_nxt = S_LOAD;
        end
        S_LOAD: begin
          cursor_nxt = in_range(dir_in, lo, hi) ? dir_in : lo;
          state_nxt  = S_COMMIT;
        end
        S_READY: begin
          if (mode_q != mode)     state_nxt = S_CLAMP;
          else if (press || tick) state_nxt = S_STEP;
        end
        S_STEP: begin
          // push_q still holds the code that caused this step.
          unique case (push_q)
            PUSH_DEC: cursor_nxt = (cursor == lo) ? (wrap_en ? hi : lo) : cursor - ADDR_W'(1);
            PUSH_INC: cursor_nxt = (cursor == hi) ? (wrap_en ? lo : hi) : cursor + ADDR_W'(1);
            default:  ;
          endcase
          state_nxt = S_COMMIT;
        end
        S_CLAMP: begin
          if (!in_range(cursor, lo, hi)) cursor_nxt = lo;
          state_nxt = S_COMMIT;
        end
        S_COMMIT: state_nxt = S_READY;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cursor    <= '0;
      dir_out   <= '0;
      dir_valid <= 1'b0;
      push_q    <= 2'b00;
      mode_q    <= M_NONE;
      // Starts high so an edit session only opens on a genuine rising edge of enable after reset.
      enable_q  <= 1'b1;
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      cursor    <= cursor_nxt;
      push_q    <= push;
      mode_q    <= mode;
      enable_q  <= enable;
      hold_cnt  <= hold_cnt_nxt;
      repeating <= repeating_nxt;
      dir_valid <= (state_nxt == S_COMMIT);
      if (state_nxt == S_COMMIT) dir_out <= cursor_nxt;
    end
  end

endmodule

// File: tb/tb_selector_posicion_param.sv
// Scoreboard bench for selector_posicion_param: one wrapping and one saturating instance share
// the same directed stimulus; a monitor compares every dir_valid pulse against queued values.
module tb_selector_posicion_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] dir_in;
  logic [1:0] push;
  logic       camb_crono, camb_hora, camb_fecha;
  logic [7:0] dir_out_w, dir_out_s;
  logic       dir_valid_w, dir_valid_s;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_w[$];
  logic [7:0] exp_s[$];

  always #5 clk = ~clk;

  selector_posicion_param #(.WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in), .push(push),
    .camb_crono(camb_crono), .camb_hora(camb_hora), .camb_fecha(camb_fecha),
    .dir_out(dir_out_w), .dir_valid(dir_valid_w)
  );

  selector_posicion_param #(.WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in), .push(push),
    .camb_crono(camb_crono), .camb_hora(camb_hora), .camb_fecha(camb_fecha),
    .dir_out(dir_out_s), .dir_valid(dir_valid_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every commit strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dir_valid_w) begin
      if (exp_w.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_valid_wrap: dir_out=%0d, expected no pulse at %0t", dir_out_w, $time);
      end else begin
        check("dir_out_wrap", dir_out_w, exp_w.pop_front());
      end
    end
    if (dir_valid_s) begin
      if (exp_s.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_valid_sat: dir_out=%0d, expected no pulse at %0t", dir_out_s, $time);
      end else begin
        check("dir_out_sat", dir_out_s, exp_s.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect2(input logic [7:0] w, input logic [7:0] s);
    exp_w.push_back(w);
    exp_s.push_back(s);
  endtask

  task automatic press(input logic [1:0] code, input logic [7:0] w, input logic [7:0] s);
    expect2(w, s);
    push = code;
    cyc(1);
    push = 2'b00;
    cyc(4);
  endtask

  task automatic load(input logic [7:0] d, input logic [7:0] w, input logic [7:0] s);
    enable = 1'b0;
    cyc(2);
    dir_in = d;
    expect2(w, s);
    enable = 1'b1;
    cyc(4);
  endtask

  task automatic mode_set(input logic c, input logic h, input logic f,
                          input logic [7:0] w, input logic [7:0] s);
    expect2(w, s);
    camb_crono = c;
    camb_hora  = h;
    camb_fecha = f;
    cyc(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; dir_in = '0; push = 2'b00;
    camb_crono = 1'b0; camb_hora = 1'b0; camb_fecha = 1'b0;
    #1;
    check("reset_dir_out", dir_out_w, 0);
    check("reset_dir_valid", dir_valid_w, 0);
    cyc(2);
    reset = 1'b1;
    cyc(2);

    // Load in hora mode: two edges from enable rising to the commit.
    camb_hora = 1'b1;
    dir_in    = 8'd6;
    expect2(8'd6, 8'd6);
    enable = 1'b1;
    cyc(1);
    check("load_latency_edge1", dir_valid_w, 0);
    cyc(1);
    check("load_latency_edge2", dir_valid_w, 1);
    cyc(2);
    load(8'd2, 8'd5, 8'd5);

    // Step right to the top of hora, then past it: wrap vs saturate.
    press(2'b10, 8'd6, 8'd6);
    press(2'b10, 8'd7, 8'd7);
    press(2'b10, 8'd5, 8'd7);

    // Into crono: both cursors are outside [1,4] and clamp to 1.
    mode_set(1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

    // Hold left for 20 cycles: press plus ticks at counts 8, 12, 16.
    expect2(8'd4, 8'd1);
    expect2(8'd3, 8'd1);
    expect2(8'd2, 8'd1);
    expect2(8'd1, 8'd1);
    push = 2'b01;
    cyc(20);
    push = 2'b00;
    cyc(6);

    // Cursor to 3, then fecha clamps to 8 and crono clamps back to 1.
    press(2'b10, 8'd2, 8'd2);
    press(2'b10, 8'd3, 8'd3);
    mode_set(1'b0, 1'b0, 1'b1, 8'd8, 8'd8);
    mode_set(1'b1, 1'b0, 1'b0, 8'd1, 8'd1);

    // Mode change and press in the same cycle: only the clamp commits.
    expect2(8'd5, 8'd5);
    camb_crono = 1'b0;
    camb_hora  = 1'b1;
    push       = 2'b10;
    cyc(1);
    push = 2'b00;
    cyc(4);

    // crono outranks hora; then fecha alone; then left at the fecha floor.
    mode_set(1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
    mode_set(1'b0, 1'b0, 1'b1, 8'd8, 8'd8);
    press(2'b01, 8'd10, 8'd8);

    // Enable drops the cycle after a press: the step never commits.
    push = 2'b10;
    cyc(1);
    push   = 2'b00;
    enable = 1'b0;
    cyc(4);
    check("no_commit_after_disable", dir_out_w, 10);
    dir_in = 8'd9;
    expect2(8'd9, 8'd9);
    enable = 1'b1;
    cyc(4);

    // No mode: full range, modular stepping across 255/0.
    mode_set(1'b0, 1'b0, 1'b0, 8'd9, 8'd9);
    load(8'd255, 8'd255, 8'd255);
    press(2'b10, 8'd0, 8'd0);
    press(2'b01, 8'd255, 8'd255);

    // Asynchronous reset in the middle of a step.
    push = 2'b10;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_dir_out", dir_out_w, 0);
    check("async_reset_dir_valid", dir_valid_w, 0);
    check("async_reset_dir_out_sat", dir_out_s, 0);
    @(negedge clk);
    push = 2'b00;
    cyc(1);
    reset = 1'b1;
    cyc(8);
    check("idle_after_reset_dir_out", dir_out_w, 0);

    check("pending_wrap", exp_w.size(), 0);
    check("pending_sat", exp_s.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
